// File: rtl/axi_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_mem_slave
// Brief    : AXI-Lite line-memory responder, 128-bit lines, fixed access latency.
//            Optional upper-address range check enabled by MEM_OOR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_mem_slave #(
    parameter int memAddrWidth = 15,
    parameter int LATENCY      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  readAddr_addr,
    input  logic         readAddr_valid,
    output logic         readAddr_ready,
    output logic [127:0] readData_data,
    output logic         readData_valid,
    input  logic         readData_ready,
    input  logic [31:0]  writeAddr_addr,
    input  logic         writeAddr_valid,
    output logic         writeAddr_ready,
    input  logic [127:0] writeData_data,
    input  logic [15:0]  writeData_strb,
    input  logic         writeData_valid,
    output logic         writeData_ready,
    output logic [31:0]  writeResp_msg,
    output logic         writeResp_valid,
    input  logic         writeResp_ready
);

    localparam int         c_IDX_W    = memAddrWidth - 4;
    localparam int         c_DEPTH    = 1 << c_IDX_W;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [31:0] c_OKAY    = 32'd0;
    localparam logic [31:0] c_SLVERR  = 32'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_WAIT = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [3:0]           r_cnt_q, w_cnt_d;
    logic [c_IDX_W-1:0]   r_idx_q, w_idx_d;
    logic                 r_oor_q, w_oor_d;
    logic [127:0]         r_rdata_q, w_rdata_d;
    logic [31:0]          r_bresp_q, w_bresp_d;
    logic                 r_up_q;
    logic                 w_commit;
    logic                 w_rd_oor;
    logic                 w_wr_oor;
    logic [127:0]         w_mem_rd;
    logic                 w_unused_addr;

    logic [127:0]         r_mem [c_DEPTH];

`ifdef MEM_OOR_CHECK_EN
    assign w_rd_oor      = |readAddr_addr[31:memAddrWidth];
    assign w_wr_oor      = |writeAddr_addr[31:memAddrWidth];
    assign w_unused_addr = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};
`else
    assign w_rd_oor      = 1'b0;
    assign w_wr_oor      = 1'b0;
    assign w_unused_addr = ^{readAddr_addr[31:memAddrWidth], readAddr_addr[3:0],
                             writeAddr_addr[31:memAddrWidth], writeAddr_addr[3:0]};
`endif

    assign w_mem_rd = r_mem[r_idx_q];

    // r_up_q holds the readys low until the first cycle after reset release
    assign readAddr_ready  = r_up_q && (r_state_q == IDLE);
    assign writeAddr_ready = r_up_q && (r_state_q == IDLE) && !readAddr_valid;
    assign writeData_ready = (r_state_q == WR_DATA);
    assign readData_valid  = (r_state_q == RD_RESP);
    assign writeResp_valid = (r_state_q == WR_RESP);
    assign readData_data   = r_rdata_q;
    assign writeResp_msg   = r_bresp_q;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_idx_d   = r_idx_q;
        w_oor_d   = r_oor_q;
        w_rdata_d = r_rdata_q;
        w_bresp_d = r_bresp_q;
        w_commit  = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (r_up_q && readAddr_valid) begin
                    w_state_d = RD_WAIT;
                    w_idx_d   = readAddr_addr[memAddrWidth-1:4];
                    w_oor_d   = w_rd_oor;
                    w_cnt_d   = c_CNT_LOAD;
                end else if (r_up_q && writeAddr_valid) begin
                    w_state_d = WR_DATA;
                    w_idx_d   = writeAddr_addr[memAddrWidth-1:4];
                    w_oor_d   = w_wr_oor;
                end
            end
            RD_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = RD_RESP;
                    w_rdata_d = r_oor_q ? 128'd0 : w_mem_rd;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (readData_ready) begin
                    w_state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (writeData_valid) begin
                    w_commit  = !r_oor_q;
                    w_bresp_d = r_oor_q ? c_SLVERR : c_OKAY;
                    w_state_d = WR_WAIT;
                    w_cnt_d   = c_CNT_LOAD;
                end
            end
            WR_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = WR_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            WR_RESP: begin
                if (writeResp_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= 4'd0;
            r_idx_q   <= '0;
            r_oor_q   <= 1'b0;
            r_rdata_q <= 128'd0;
            r_bresp_q <= 32'd0;
            r_up_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_oor_q   <= w_oor_d;
            r_rdata_q <= w_rdata_d;
            r_bresp_q <= w_bresp_d;
            r_up_q    <= 1'b1;
        end
    end

    // Memory is not reset; a commit coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (rst && w_commit) begin
            for (int i = 0; i < 16; i++) begin
                if (writeData_strb[i]) begin
                    r_mem[r_idx_q][i*8 +: 8] <= writeData_data[i*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
